// File: rtl/xc_fifo_xmt.sv
// xc_fifo_xmt: FIFO-to-stream burst transmitter; define XC_FIFO_XMT_TIMEOUT_EN for partial-burst timeout closure.
module xc_fifo_xmt #(
    parameter int WIDTH      = 32,
    parameter int LOG2_BURST = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  fifo_ne_i,
    input  logic [WIDTH-1:0]      fifo_data_i,
    output logic                  fifo_rd_o,
    input  logic [LOG2_BURST-1:0] burst_len_i,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [WIDTH-1:0]      tx_data_o,
    output logic                  tx_last_o,
    output logic                  busy_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;
    localparam logic [LOG2_BURST-1:0] CNT_ONE = 1;

    logic [1:0]            state_q, state_d;
    logic [LOG2_BURST-1:0] cnt_q, cnt_d, len_q, len_d, cnt_inc;
    logic                  tx_valid_q, tx_valid_d, tx_last_q, tx_last_d;
    logic [WIDTH-1:0]      tx_data_q, tx_data_d, load_data;
    logic                  out_free, pop, load, load_last;
    logic                  pend_full, pend_next, hold_next;

`ifdef XC_FIFO_XMT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
    localparam logic [TW-1:0] T_ONE = 1;

    logic [TW-1:0]    timer_q, timer_d;
    logic             pend_v_q, pend_v_d, pend_done, timed;
    logic [WIDTH-1:0] pend_q, pend_d;
`endif

    always_comb begin
        out_free = !tx_valid_q || tx_ready_i;
        cnt_inc  = cnt_q + CNT_ONE;
`ifdef XC_FIFO_XMT_TIMEOUT_EN
        // A pending word only moves on once we know whether it closes the burst.
        pend_done = cnt_inc == len_q;
        timed     = timer_q == T_MAX;
        load      = pend_v_q && out_free && !clr_i && (fifo_ne_i || pend_done || timed);
        load_last = pend_done || (timed && !fifo_ne_i);
        load_data = pend_q;
        pop       = fifo_ne_i && (!pend_v_q || load) && !clr_i && !rst_i;
        pend_v_d  = !clr_i && (pop || (pend_v_q && !load));
        pend_d    = pop ? fifo_data_i : pend_q;
        pend_full = pend_v_q;
        pend_next = pend_v_d;
        hold_next = pend_v_d && !fifo_ne_i && !pend_done;
`else
        load      = fifo_ne_i && out_free && !clr_i && !rst_i;
        pop       = load;
        load_last = cnt_inc == ((state_q == IDLE) ? burst_len_i : len_q);
        load_data = fifo_data_i;
        pend_full = 1'b0;
        pend_next = 1'b0;
        hold_next = 1'b0;
`endif
        len_d      = (state_q == IDLE && pop) ? burst_len_i : len_q;
        tx_valid_d = !clr_i && (load || (tx_valid_q && !tx_ready_i));
        tx_last_d  = !clr_i && (load ? load_last : (tx_last_q && !tx_ready_i));
        tx_data_d  = load ? load_data : tx_data_q;
        cnt_d      = clr_i ? '0 : load ? (load_last ? '0 : cnt_inc) : cnt_q;
        // A burst is over once the count has wrapped and nothing is left in flight.
        state_d    = clr_i ? IDLE :
                     pop ? BURST :
                     (state_q == IDLE) ? IDLE :
                     (cnt_d == '0 && !tx_valid_d && !pend_next) ? IDLE :
                     hold_next ? HOLD : BURST;
`ifdef XC_FIFO_XMT_TIMEOUT_EN
        timer_d    = (state_d == HOLD) ? (timed ? timer_q : timer_q + T_ONE) : '0;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            tx_valid_q <= tx_valid_d;
            tx_last_q  <= tx_last_d;
            tx_data_q  <= tx_data_d;
        end
    end

`ifdef XC_FIFO_XMT_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            timer_q  <= '0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
        end else begin
            timer_q  <= timer_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
        end
    end
`endif

    assign fifo_rd_o  = pop;
    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign tx_last_o  = tx_last_q;
    assign busy_o     = (state_q != IDLE) || tx_valid_q || pend_full;
endmodule

// File: tb/tb_xc_fifo_xmt.sv
// tb_xc_fifo_xmt: directed vectors, corner sequences and a randomized scoreboard for xc_fifo_xmt.
module tb_xc_fifo_xmt;
    localparam int W  = 32;
    localparam int LB = 4;

    logic          clk = 1'b0;
    logic          rst_i, clr_i, fifo_ne_i, fifo_rd_o, tx_valid_o, tx_ready_i, tx_last_o, busy_o;
    logic [W-1:0]  fifo_data_i, tx_data_o;
    logic [LB-1:0] burst_len_i;

    always #5 clk = ~clk;

    xc_fifo_xmt #(.WIDTH(W), .LOG2_BURST(LB), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .fifo_ne_i(fifo_ne_i),
        .fifo_data_i(fifo_data_i), .fifo_rd_o(fifo_rd_o), .burst_len_i(burst_len_i),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .tx_data_o(tx_data_o),
        .tx_last_o(tx_last_o), .busy_o(busy_o)
    );

    int tests = 0;
    int fails = 0;
    logic [W-1:0] fq[$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; clr_i = 1'b0; fifo_ne_i = 1'b0; fifo_data_i = '0;
        tx_ready_i = 1'b0; burst_len_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        fq.delete();
    endtask

`ifndef XC_FIFO_XMT_TIMEOUT_EN
    typedef struct {
        logic rst, clr, ne, rdy;
        logic [W-1:0] d;
        logic [LB-1:0] len;
        logic e_rd, e_v, e_l, e_b, chk_d;
        logic [W-1:0] e_d;
    } vec_t;
    typedef struct { logic [W-1:0] d; logic l; } beat_t;

    vec_t  tv[16];
    beat_t eq[$];
    int    beat, blen, nrd, nxfer, nlast;
    logic  stall_q, hold_l;
    logic [W-1:0] hold_d;

    function automatic vec_t mk(input logic rst, clr, ne, rdy, input logic [W-1:0] d,
                                input logic [LB-1:0] len, input logic rd, v, l, b, cd,
                                input logic [W-1:0] ed);
        vec_t r;
        r.rst = rst; r.clr = clr; r.ne = ne; r.rdy = rdy; r.d = d; r.len = len;
        r.e_rd = rd; r.e_v = v; r.e_l = l; r.e_b = b; r.chk_d = cd; r.e_d = ed;
        return r;
    endfunction

    task automatic model_reset();
        eq.delete(); beat = 0; blen = 1 << LB; nrd = 0; nxfer = 0; nlast = 0; stall_q = 1'b0;
    endtask

    // One clock of the FIFO model plus scoreboard; checks pop rule, stalls, order and latency.
    task automatic tick(input logic rdy, input logic clr, input logic [LB-1:0] len, input int push_pct);
        beat_t b;
        logic pop, idle;
        logic [W-1:0] pd;
        tx_ready_i = rdy; clr_i = clr; burst_len_i = len;
        fifo_ne_i = fq.size() != 0;
        fifo_data_i = fifo_ne_i ? fq[0] : $urandom;
        #1;
        check("rd_rule", {31'b0, fifo_rd_o}, {31'b0, !clr && fifo_ne_i && (!tx_valid_o || tx_ready_i)});
        if (stall_q) begin
            check("stall_valid", {31'b0, tx_valid_o}, 1);
            check("stall_data", tx_data_o, hold_d);
            check("stall_last", {31'b0, tx_last_o}, {31'b0, hold_l});
        end
        idle = eq.size() == 0 && beat == 0;
        if (tx_valid_o && tx_ready_i) begin
            tests++;
            if (eq.size() == 0) begin
                fails++;
                $display("FAIL xfer_unexpected: got data %0h with nothing outstanding", tx_data_o);
            end else begin
                tests--;
                b = eq.pop_front();
                check("xfer_data", tx_data_o, b.d);
                check("xfer_last", {31'b0, tx_last_o}, {31'b0, b.l});
                nxfer++;
                if (tx_last_o) nlast++;
            end
        end
        pop = fifo_rd_o;
        pd = fifo_data_i;
        if (pop) begin
            if (idle) blen = (len == 0) ? (1 << LB) : int'(len);
            beat++;
            b.d = pd;
            b.l = beat == blen;
            if (b.l) beat = 0;
            eq.push_back(b);
            nrd++;
        end
        stall_q = tx_valid_o && !tx_ready_i && !clr;
        hold_d = tx_data_o;
        hold_l = tx_last_o;
        @(posedge clk);
        #1;
        if (pop) begin
            void'(fq.pop_front());
            check("latency_valid", {31'b0, tx_valid_o}, 1);
            check("latency_data", tx_data_o, pd);
        end
        if (clr) begin
            eq.delete();
            beat = 0;
            check("clr_valid", {31'b0, tx_valid_o}, 0);
            check("clr_busy", {31'b0, busy_o}, 0);
        end
        if ($urandom_range(0, 99) < push_pct) fq.push_back($urandom);
    endtask
`else
    logic         lv[64], ll[64], lb[64];
    logic [W-1:0] ld[64];

    task automatic run_log(input int n, input int push_at, input logic [W-1:0] pw);
        logic p;
        for (int e = 1; e <= n; e++) begin
            if (e == push_at) fq.push_back(pw);
            tx_ready_i = 1'b1; burst_len_i = 4'd8; clr_i = 1'b0;
            fifo_ne_i = fq.size() != 0;
            fifo_data_i = fifo_ne_i ? fq[0] : '0;
            #1 p = fifo_rd_o;
            @(posedge clk);
            #1;
            if (p) void'(fq.pop_front());
            lv[e] = tx_valid_o; ld[e] = tx_data_o; ll[e] = tx_last_o; lb[e] = busy_o;
        end
    endtask
`endif

    initial begin
`ifndef XC_FIFO_XMT_TIMEOUT_EN
        tv[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'hA1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tv[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h11, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11);
        tv[2]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h12, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12);
        tv[3]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h13, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12);
        tv[4]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h13, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tv[5]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h21, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h21);
        tv[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 4'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22);
        tv[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h23, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22);
        tv[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h23, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tv[9]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h31, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h31);
        tv[10] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h32, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h32);
        tv[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h33, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h32);
        tv[12] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h41, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tv[13] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h51, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h51);
        tv[14] = mk(1'b0, 1'b0, 1'b1, 1'b1, 32'h52, 4'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h52);
        tv[15] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h53, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        rst_i = 1'b1; clr_i = 1'b0; fifo_ne_i = 1'b0; fifo_data_i = '0; tx_ready_i = 1'b0; burst_len_i = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            rst_i = tv[i].rst; clr_i = tv[i].clr; fifo_ne_i = tv[i].ne; tx_ready_i = tv[i].rdy;
            fifo_data_i = tv[i].d; burst_len_i = tv[i].len;
            #1 check($sformatf("vec%0d_rd", i), {31'b0, fifo_rd_o}, {31'b0, tv[i].e_rd});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), {31'b0, tx_valid_o}, {31'b0, tv[i].e_v});
            check($sformatf("vec%0d_last", i), {31'b0, tx_last_o}, {31'b0, tv[i].e_l});
            check($sformatf("vec%0d_busy", i), {31'b0, busy_o}, {31'b0, tv[i].e_b});
            if (tv[i].chk_d) check($sformatf("vec%0d_data", i), tx_data_o, tv[i].e_d);
        end

        // Eight words, bursts of four, sink always ready.
        do_reset(); model_reset();
        for (int i = 0; i < 8; i++) fq.push_back(32'h100 + i);
        repeat (8) tick(1'b1, 1'b0, 4'd4, 0);
        check("b4_rd_cycles", nrd, 8);
        tick(1'b1, 1'b0, 4'd4, 0);
        check("b4_beats_consecutive", nxfer, 8);
        repeat (3) tick(1'b1, 1'b0, 4'd4, 0);
        check("b4_last_count", nlast, 2);
        check("b4_idle", {31'b0, busy_o}, 0);

        // Full 16-beat burst with a sink stalling every other cycle.
        do_reset(); model_reset();
        for (int i = 0; i < 16; i++) fq.push_back(32'h200 + i);
        for (int i = 0; i < 48; i++) tick(logic'(i % 2), 1'b0, 4'd0, 0);
        check("b16_beats", nxfer, 16);
        check("b16_last_count", nlast, 1);

        // Randomized traffic, stalls, flushes and mid-burst length changes.
        do_reset(); model_reset();
        for (int i = 0; i < 4000; i++)
            tick($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 2, LB'($urandom), 40);
        for (int i = 0; i < 200 && (eq.size() != 0 || fq.size() != 0); i++)
            tick(1'b1, 1'b0, LB'($urandom), 0);
        check("rand_drained", eq.size() + fq.size(), 0);
`else
        // Three words then an empty FIFO: the third beat closes the burst after the timeout.
        do_reset();
        fq.push_back(32'hC1); fq.push_back(32'hC2); fq.push_back(32'hC3);
        run_log(21, 0, '0);
        check("to_w1_valid", {31'b0, lv[2]}, 1);
        check("to_w1_data", ld[2], 32'hC1);
        check("to_w2_data", ld[3], 32'hC2);
        check("to_w2_last", {31'b0, ll[3]}, 0);
        check("to_gap_start", {31'b0, lv[4]}, 0);
        check("to_gap_end", {31'b0, lv[19]}, 0);
        check("to_w3_valid", {31'b0, lv[20]}, 1);
        check("to_w3_data", ld[20], 32'hC3);
        check("to_w3_last", {31'b0, ll[20]}, 1);
        check("to_idle", {31'b0, lb[21]}, 0);

        // A fourth word arriving during the hold keeps the burst open.
        do_reset();
        fq.push_back(32'hD1); fq.push_back(32'hD2); fq.push_back(32'hD3);
        run_log(32, 14, 32'hD4);
        check("re_gap", {31'b0, lv[13]}, 0);
        check("re_w3_valid", {31'b0, lv[14]}, 1);
        check("re_w3_data", ld[14], 32'hD3);
        check("re_w3_last", {31'b0, ll[14]}, 0);
        check("re_busy", {31'b0, lb[15]}, 1);
        check("re_gap2", {31'b0, lv[30]}, 0);
        check("re_w4_valid", {31'b0, lv[31]}, 1);
        check("re_w4_data", ld[31], 32'hD4);
        check("re_w4_last", {31'b0, ll[31]}, 1);
        check("re_idle", {31'b0, lb[32]}, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/xc_fifo_xmt.md
XC_FIFO_XMT -- requirements
Module: xc_fifo_xmt

Interface
REQ-001 Parameter WIDTH, default 32: data word width.
REQ-002 Parameter LOG2_BURST, default 4: burst beat counter width.
REQ-003 Parameter TIMEOUT, default 16: idle cycles before a partial burst is closed (TIMEOUT_EN builds only).
REQ-004 clk_i  input  1  clock; one clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 clr_i  input  1  synchronous flush of burst state and output stage.
REQ-007 fifo_ne_i  input  1  upstream FIFO not-empty.
REQ-008 fifo_data_i  input  WIDTH  upstream FIFO head word, valid whenever fifo_ne_i=1.
REQ-009 fifo_rd_o  output  1  pop strobe to FIFO read-pointer advance, combinational.
REQ-010 burst_len_i  input  LOG2_BURST  beats per burst; 0 means 2^LOG2_BURST.
REQ-011 tx_valid_o / tx_ready_i  output/input  1  downstream valid/ready handshake.
REQ-012 tx_data_o  output  WIDTH  transmitted word, registered.
REQ-013 tx_last_o  output  1  final beat of a burst, registered.
REQ-014 busy_o  output  1  high when state is not IDLE or any stage holds a word.

Function
REQ-015 Transfer occurs on a cycle with tx_valid_o=1 and tx_ready_i=1; while tx_valid_o=1 and tx_ready_i=0, tx_data_o and tx_last_o SHALL hold stable.
REQ-016 fifo_rd_o SHALL assert only when fifo_ne_i=1 and the receiving stage is empty or drains that cycle; never with fifo_ne_i=0.
REQ-017 FSM states IDLE, BURST, HOLD; IDLE->BURST on first pop; BURST->IDLE when the beat marked tx_last_o transfers; HOLD only in TIMEOUT_EN builds.
REQ-018 Beat counter (LOG2_BURST bits) counts words loaded into the output register in the current burst; the word loaded as beat burst_len_i is marked tx_last_o=1 and the counter returns to 0; wraps with no overflow state.
REQ-019 burst_len_i is sampled at IDLE->BURST and held for the burst; mid-burst changes have no effect.
REQ-020 Without TIMEOUT_EN, a word popped at edge N appears on tx_data_o after edge N (latency 1); with back-to-back pops and tx_ready_i=1, throughput is one word per cycle.
REQ-021 FIFO empty mid-burst without TIMEOUT_EN: burst stays open indefinitely; tx_valid_o drops after the last held word transfers; tx_last_o only on count.
REQ-022 Simultaneous output transfer and pop: new word loads the same edge; no bubble.
REQ-023 clr_i=1: tx_valid_o, tx_last_o, fifo_rd_o-derived loads, beat counter, timer cleared next edge, state IDLE, regardless of handshake; fifo_rd_o=0 while clr_i=1.
REQ-024 rst_i has priority over clr_i.

Reset
REQ-025 On rst_i: tx_valid_o=0, tx_last_o=0, tx_data_o=0, busy_o=0, state IDLE, beat counter 0, timer 0, pending stage empty.
REQ-026 fifo_rd_o=0 while rst_i=1.
REQ-027 Reset mid-burst discards held words; no partial transfer completes after reset.

Configuration
REQ-028 Macro XC_FIFO_XMT_TIMEOUT_EN enables partial-burst closure.
REQ-029 Defined: a pending register sits before the output register (latency 2); a pending word advances when the output stage is free and (fifo_ne_i=1 -> tx_last_o=0, or it completes the count -> tx_last_o=1, or timer reaches TIMEOUT -> tx_last_o=1).
REQ-030 Defined: state HOLD entered when pending is full, fifo_ne_i=0 and count not reached; timer increments each HOLD cycle, resets on leaving HOLD; fifo_ne_i=1 in HOLD returns to BURST with timer 0.
REQ-031 Not defined: no pending register, timer or HOLD state; behaviour per REQ-020/021.

Verification
REQ-032 burst_len_i=4, 8 words in FIFO, tx_ready_i=1 -> 8 consecutive beats, tx_last_o on beats 4 and 8, fifo_rd_o high 8 cycles.
REQ-033 burst_len_i=0, 16 words, tx_ready_i toggling 1/0 -> 16 beats, data order preserved, tx_last_o on beat 16 only, data stable across stalls.
REQ-034 TIMEOUT_EN, TIMEOUT=16, burst_len_i=8, 3 words then FIFO empty -> beat 3 presented 16 cycles after HOLD entry with tx_last_o=1, state IDLE after transfer.
REQ-035 TIMEOUT_EN, same as above but 4th word arrives at HOLD cycle 10 -> beat 3 tx_last_o=0, timer resets, burst continues.
REQ-036 clr_i pulse with tx_valid_o=1, tx_ready_i=0, mid-burst beat 2 of 4 -> next cycle tx_valid_o=0, busy_o=0, next burst restarts count at beat 1.
REQ-037 rst_i asserted mid-burst -> all outputs at reset values next edge; fifo_rd_o=0 during reset.
